// File: rtl/mips_cpu_pkg.sv
// Shared types and address constants for the MIPS CPU control path.
// The state encoding is visible on the debug port, so its values are fixed.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_unit.sv
// PC plus one-deep branch-delay-slot tracking; all state moves only on i_commit.
// Halts are requested through o_halt_next once the delay slot of a jump to HALT_ADDR is committing.
module mips_cpu_pc_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_commit,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_pc,
    output logic        o_halt_next
);

    logic [31:0] r_pc;
    logic        r_delay_pending;
    logic [31:0] r_delay_target;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc            <= RESET_VECTOR;
            r_delay_pending <= 1'b0;
            r_delay_target  <= 32'd0;
        end else if (i_commit) begin
            if (r_delay_pending) begin
                // Delay slot done: take the stored target; a redirect here is dropped.
                r_pc            <= r_delay_target;
                r_delay_pending <= 1'b0;
            end else begin
                r_pc <= r_pc + 32'd4;
                if (i_redirect) begin
                    r_delay_pending <= 1'b1;
                    r_delay_target  <= i_redirect_target;
                end
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_halt_next = r_delay_pending && (r_delay_target == HALT_ADDR);

endmodule

// File: rtl/mips_cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer on a shared bus: 2 cycles per ALU op, 3 per load/store.
// A high i_waitrequest holds FETCH or MEM in place; reset is synchronous and overrides everything.
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_waitrequest,
    input  logic        i_mem_access,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_active,
    output logic [31:0] o_pc,
    output logic        o_fetch_read,
    output logic        o_addr_sel,
    output logic        o_instr_latch_en,
    output logic        o_decode_enable,
    output logic        o_mem_phase,
    output logic        o_reg_commit,
    output logic [1:0]  o_state,
    output logic [31:0] o_instr_count
);

    seq_state_t  r_state;
    logic [31:0] r_instr_count;
    logic        w_commit;
    logic        w_halt_next;

    assign w_commit = !i_reset &&
                      (((r_state == EXEC) && !i_mem_access) ||
                       ((r_state == MEM)  && !i_waitrequest));

    mips_cpu_pc_unit #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR)
    ) u_pc (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_commit          (w_commit),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_pc              (o_pc),
        .o_halt_next       (w_halt_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= FETCH;
            r_instr_count <= 32'd0;
        end else begin
            unique case (r_state)
                FETCH: if (!i_waitrequest) r_state <= EXEC;
                EXEC: begin
                    if (i_mem_access)     r_state <= MEM;
                    else if (w_halt_next) r_state <= HALTED;
                    else                  r_state <= FETCH;
                end
                MEM: begin
                    if (!i_waitrequest) r_state <= w_halt_next ? HALTED : FETCH;
                end
                HALTED: r_state <= HALTED;
            endcase
            if (w_commit) r_instr_count <= r_instr_count + 32'd1;
        end
    end

    // Strobes are a pure decode of the current state, forced low while reset is high.
    always_comb begin
        o_active         = !i_reset && (r_state != HALTED);
        o_fetch_read     = !i_reset && (r_state == FETCH);
        o_instr_latch_en = !i_reset && (r_state == FETCH) && !i_waitrequest;
        o_addr_sel       = !i_reset && (r_state == MEM);
        o_mem_phase      = !i_reset && (r_state == MEM);
        o_decode_enable  = !i_reset && ((r_state == EXEC) || (r_state == MEM));
        o_reg_commit     = w_commit;
    end

    assign o_state       = r_state;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Directed bench for mips_cpu_sequencer: per-cycle vectors of inputs and expected outputs.
module tb_mips_cpu_sequencer;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    // Flag order: fetch_read, addr_sel, instr_latch_en, decode_enable, mem_phase, reg_commit, active
    localparam logic [6:0] F_RST    = 7'b0000000;
    localparam logic [6:0] F_FSTALL = 7'b1000001;
    localparam logic [6:0] F_FLATCH = 7'b1010001;
    localparam logic [6:0] F_EXEC   = 7'b0001001;
    localparam logic [6:0] F_EXECC  = 7'b0001011;
    localparam logic [6:0] F_MEM    = 7'b0101101;
    localparam logic [6:0] F_MEMC   = 7'b0101111;
    localparam logic [6:0] F_HALT   = 7'b0000000;

    typedef struct packed {
        logic [3:0]  in;     // reset, waitrequest, mem_access, redirect
        logic [31:0] tgt;
        logic [1:0]  st;
        logic [31:0] pc;
        logic [6:0]  fl;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b0;
    logic        mem_access = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        active, fetch_read, addr_sel, instr_latch_en;
    logic        decode_enable, mem_phase, reg_commit;
    logic [31:0] pc, instr_count;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [18];

    always #5 clk = ~clk;

    mips_cpu_sequencer dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_waitrequest     (waitrequest),
        .i_mem_access      (mem_access),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .o_active          (active),
        .o_pc              (pc),
        .o_fetch_read      (fetch_read),
        .o_addr_sel        (addr_sel),
        .o_instr_latch_en  (instr_latch_en),
        .o_decode_enable   (decode_enable),
        .o_mem_phase       (mem_phase),
        .o_reg_commit      (reg_commit),
        .o_state           (state),
        .o_instr_count     (instr_count)
    );

    function automatic vec_t mk(input logic [3:0] in, input logic [31:0] tgt, input logic [1:0] st,
                                input logic [31:0] exp_pc, input logic [6:0] fl, input logic [31:0] cnt);
        vec_t v;
        v.in = in; v.tgt = tgt; v.st = st; v.pc = exp_pc; v.fl = fl; v.cnt = cnt;
        return v;
    endfunction

    // Drive inputs away from the rising edge, then compare the outputs of the current cycle.
    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [6:0] got_fl;
        @(negedge clk);
        {reset, waitrequest, mem_access, redirect} = v.in;
        redirect_target = v.tgt;
        #1;
        got_fl = {fetch_read, addr_sel, instr_latch_en, decode_enable, mem_phase, reg_commit, active};
        n_tests++;
        if ({state, pc, got_fl, instr_count} !== {v.st, v.pc, v.fl, v.cnt}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got st=%0d pc=%h flags=%b cnt=%0d, expected st=%0d pc=%h flags=%b cnt=%0d",
                     tag, idx, state, pc, got_fl, instr_count, v.st, v.pc, v.fl, v.cnt);
        end
    endtask

    initial begin
        tbl[0]  = mk(4'b1000, 32'd0,         2'd0, RV,             F_RST,    0);
        tbl[1]  = mk(4'b0000, 32'd0,         2'd0, RV,             F_FLATCH, 0);
        tbl[2]  = mk(4'b0000, 32'd0,         2'd1, RV,             F_EXECC,  0);
        tbl[3]  = mk(4'b0000, 32'd0,         2'd0, RV + 32'h4,     F_FLATCH, 1);
        tbl[4]  = mk(4'b0010, 32'd0,         2'd1, RV + 32'h4,     F_EXEC,   1);
        tbl[5]  = mk(4'b0110, 32'd0,         2'd2, RV + 32'h4,     F_MEM,    1);
        tbl[6]  = mk(4'b0110, 32'd0,         2'd2, RV + 32'h4,     F_MEM,    1);
        tbl[7]  = mk(4'b0010, 32'd0,         2'd2, RV + 32'h4,     F_MEMC,   1);
        tbl[8]  = mk(4'b0100, 32'd0,         2'd0, RV + 32'h8,     F_FSTALL, 2);
        tbl[9]  = mk(4'b0000, 32'd0,         2'd0, RV + 32'h8,     F_FLATCH, 2);
        tbl[10] = mk(4'b0001, 32'hBFC00100,  2'd1, RV + 32'h8,     F_EXECC,  2);
        tbl[11] = mk(4'b0000, 32'd0,         2'd0, RV + 32'hC,     F_FLATCH, 3);
        tbl[12] = mk(4'b0001, 32'h00001234,  2'd1, RV + 32'hC,     F_EXECC,  3);
        tbl[13] = mk(4'b0000, 32'd0,         2'd0, 32'hBFC00100,   F_FLATCH, 4);
        tbl[14] = mk(4'b0000, 32'd0,         2'd1, 32'hBFC00100,   F_EXECC,  4);
        tbl[15] = mk(4'b0000, 32'd0,         2'd0, 32'hBFC00104,   F_FLATCH, 5);
        tbl[16] = mk(4'b0000, 32'd0,         2'd1, 32'hBFC00104,   F_EXECC,  5);
        tbl[17] = mk(4'b0000, 32'd0,         2'd0, 32'hBFC00108,   F_FLATCH, 6);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 18; i++) apply(tbl[i], "table", i);

        // Jump to HALT_ADDR from BFC00010 with a load in its delay slot.
        apply(mk(4'b1000, 32'd0, 2'd1, 32'hBFC00108, F_RST, 6), "halt_rst", 0);
        for (int i = 0; i < 4; i++) begin
            apply(mk(4'b0000, 32'd0, 2'd0, RV + 32'(4 * i), F_FLATCH, 32'(i)), "halt_warm_f", i);
            apply(mk(4'b0000, 32'd0, 2'd1, RV + 32'(4 * i), F_EXECC,  32'(i)), "halt_warm_e", i);
        end
        apply(mk(4'b0000, 32'd0, 2'd0, RV + 32'h10, F_FLATCH, 4), "halt_jmp_f", 0);
        apply(mk(4'b0001, 32'd0, 2'd1, RV + 32'h10, F_EXECC,  4), "halt_jmp_e", 0);
        apply(mk(4'b0000, 32'd0, 2'd0, RV + 32'h14, F_FLATCH, 5), "halt_slot_f", 0);
        apply(mk(4'b0010, 32'd0, 2'd1, RV + 32'h14, F_EXEC,   5), "halt_slot_e", 0);
        apply(mk(4'b0000, 32'd0, 2'd2, RV + 32'h14, F_MEMC,   5), "halt_slot_m", 0);
        for (int i = 0; i < 12; i++)
            apply(mk({1'b0, i[0], 1'b1, 1'b1}, RV, 2'd3, 32'd0, F_HALT, 6), "halted", i);

        // Reset while MEM is stalled with a delay slot pending.
        apply(mk(4'b1000, 32'd0, 2'd3, 32'd0, F_RST, 6), "mrst_rst", 0);
        apply(mk(4'b0000, 32'd0,        2'd0, RV,          F_FLATCH, 0), "mrst_br_f", 0);
        apply(mk(4'b0001, 32'hBFC00200, 2'd1, RV,          F_EXECC,  0), "mrst_br_e", 0);
        apply(mk(4'b0000, 32'd0,        2'd0, RV + 32'h4,  F_FLATCH, 1), "mrst_ld_f", 0);
        apply(mk(4'b0010, 32'd0,        2'd1, RV + 32'h4,  F_EXEC,   1), "mrst_ld_e", 0);
        apply(mk(4'b0110, 32'd0,        2'd2, RV + 32'h4,  F_MEM,    1), "mrst_ld_m", 0);
        apply(mk(4'b1110, 32'd0,        2'd2, RV + 32'h4,  F_RST,    1), "mrst_hit", 0);
        apply(mk(4'b0000, 32'd0,        2'd0, RV,          F_FLATCH, 0), "mrst_after_f", 0);
        apply(mk(4'b0000, 32'd0,        2'd1, RV,          F_EXECC,  0), "mrst_after_e", 0);
        apply(mk(4'b0000, 32'd0,        2'd0, RV + 32'h4,  F_FLATCH, 1), "mrst_after_f2", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_sequencer.md
Name: mips_cpu_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS CPU core.
- Owns the PC and the branch-delay-slot register, and steps each instruction through FETCH, EXEC and optional MEM phases on a single shared Avalon-style memory bus.
- Generates the decoder's clk_enable, the bus address-source select and the register-commit strobe, and drives the CPU `active` output, including halt on a jump to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, redirect target that halts the CPU after its delay slot commits.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- waitrequest  in  1  memory bus stall; the current bus access is held while high
- mem_access  in  1  decoder data_read OR data_write for the current instruction
- redirect  in  1  current instruction takes a branch/jump (decoder pc_sel != 0, condition resolved)
- redirect_target  in  32  branch/jump destination address
- active  out  1  CPU running; low in reset and after halt
- pc  out  32  address of the instruction being fetched/executed
- fetch_read  out  1  instruction read strobe on the bus
- addr_sel  out  1  bus address source: 0 = pc, 1 = ALU data address
- instr_latch_en  out  1  capture instr_readdata into the instruction register
- decode_enable  out  1  drives the decoder clk_enable
- mem_phase  out  1  qualifies decoder data_read/data_write onto the bus
- reg_commit  out  1  register-file write qualifier, one cycle per instruction
- state  out  2  current state, debug
- instr_count  out  32  committed-instruction counter

Behaviour:
- States (2-bit): FETCH=0, EXEC=1, MEM=2, HALTED=3.
- Reset (synchronous, overrides everything, including mid-MEM with waitrequest high):
  - state=FETCH, pc=RESET_VECTOR, delay_pending=0, delay_target=0, instr_count=0.
  - active=0 during the reset cycle; all strobes are 0 while reset is high.
- First cycle after reset: active=1.
- FETCH:
  - fetch_read=1, addr_sel=0.
  - waitrequest=1: remain in FETCH.
  - waitrequest=0: instr_latch_en=1 for that cycle, next state EXEC.
- EXEC:
  - decode_enable=1.
  - mem_access=1: next state MEM, no commit yet.
  - mem_access=0: reg_commit=1, PC update, next state FETCH (or HALTED).
- MEM:
  - decode_enable=1, addr_sel=1, mem_phase=1.
  - waitrequest=1: hold MEM, reg_commit=0.
  - waitrequest=0: reg_commit=1, PC update, next state FETCH (or HALTED).
- PC update, performed only on a commit cycle:
  - delay_pending=1: pc <= delay_target, delay_pending <= 0. If delay_target == HALT_ADDR, next state is HALTED instead of FETCH.
  - Else if redirect=1: pc <= pc+4, delay_pending <= 1, delay_target <= redirect_target. The delay slot is always fetched.
  - Else: pc <= pc+4, wrapping modulo 2^32.
  - Redirect asserted while delay_pending=1 (branch in a delay slot) is ignored; the first target wins.
- instr_count increments by 1 on every reg_commit cycle and wraps at 2^32.
- HALTED:
  - active=0; fetch_read, mem_phase, decode_enable, reg_commit, instr_latch_en all 0.
  - pc holds HALT_ADDR.
  - Leaves only on reset.
- Latency with waitrequest never high: 2 cycles per non-memory instruction, 3 cycles per load/store.
- All outputs are registered state or decoded combinationally from state plus inputs. reg_commit and instr_latch_en are never high simultaneously.

Decomposition:
- Package mips_cpu_pkg holds:
  - enum seq_state_t {FETCH, EXEC, MEM, HALTED};
  - constants RESET_VECTOR and HALT_ADDR.
- Sub-module mips_cpu_pc_unit:
  - contains the PC, delay_pending and delay_target registers;
  - inputs: commit, redirect, redirect_target;
  - outputs: pc, halt_next.
- The state machine and counter stay in mips_cpu_sequencer.

Test Plan:
- Reset high for 2 cycles, then low with waitrequest=0 -> pc=32'hBFC00000, state=FETCH, active=1, fetch_read=1, instr_count=0.
- Non-memory instruction, waitrequest=0 -> FETCH, EXEC, FETCH; reg_commit high exactly one cycle; pc=32'hBFC00004; instr_count=1.
- Load (mem_access=1) with waitrequest high for 2 cycles in MEM -> MEM lasts 3 cycles with mem_phase=1 and addr_sel=1; single reg_commit on the third cycle; pc+4.
- redirect=1 at pc=32'hBFC00008, target 32'hBFC00100 -> next fetch at BFC0000C; after the delay slot commits, fetch at BFC00100. A redirect asserted in the delay slot (target 32'h1234) is ignored.
- redirect to 32'h0 at pc=32'hBFC00010 -> the delay slot at BFC00014 commits, then state=HALTED, active=0, fetch_read stays 0 for 10+ cycles, instr_count frozen.
- Reset asserted in MEM with waitrequest=1 and delay_pending=1 -> next cycle state=FETCH, pc=32'hBFC00000, delay_pending=0, instr_count=0, no reg_commit pulse.
